function_generator_sequencer: RTL

Playback controller for the function generator: it steps through the single-port sample RAM at a programmable sample rate and drives the 8-bit DAC bus with a start strobe on every new sample. It also arbitrates the same RAM port between playback and the host (Caravel wishbone bridge) so waveforms can be loaded while idle or running. It sits between the wishbone register block and the RAM/DAC pins. It exports the debug strobes that are routed to mprj_io[21:16].

---
 rtl/function_generator_pkg.sv | 20 ++
 rtl/fg_ram_arbiter.sv | 69 ++++++
 rtl/function_generator_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/function_generator_pkg.sv
// rtl/function_generator_pkg.sv - shared types and constants for the function generator sequencer
// Purpose: state enum for the playback FSM, default widths, minimum sample period.
`timescale 1ns/1ps
package function_generator_pkg;

  localparam int ADDR_W_DEF   = 9;
  localparam int DATA_W_DEF   = 8;
  localparam int PERIOD_W_DEF = 16;

  // Smallest usable period: FETCH + CAPTURE + at least one WAIT cycle.
  localparam int MIN_PERIOD   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    WAIT    = 2'd3
  } fg_state_t;

endpackage

// File: rtl/fg_ram_arbiter.sv
// rtl/fg_ram_arbiter.sv - single-port sample RAM arbiter between player and host
// Purpose: player fetch has absolute priority; host gets any other cycle where it
//          requests and is not being acked. Ack and read data follow one cycle later.
// Ports:
//   clk, resetb                  clock, synchronous active-low reset
//   player_req, player_addr      player fetch request (one cycle) and address
//   host_req/we/addr/wdata       host request, held until host_ack
//   host_rdata, host_ack         host read data (valid with ack), one-cycle ack
//   ram_en/we/addr/wdata         RAM port strobes
//   ram_rdata                    registered RAM read data
`timescale 1ns/1ps
module fg_ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              player_req,
  input  logic [ADDR_W-1:0] player_addr,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic player_go;
  logic host_grant;

  // Gating with resetb keeps the port quiet while reset is held even though
  // the host may already be requesting.
  assign player_go  = resetb & player_req;
  // No re-grant in the ack cycle: the host still holds host_req there.
  assign host_grant = resetb & host_req & ~host_ack & ~player_req;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (player_go) begin
      ram_en   = 1'b1;
      ram_addr = player_addr;
    end else if (host_grant) begin
      ram_en    = 1'b1;
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      host_ack <= 1'b0;
    end else begin
      host_ack <= host_grant;
    end
  end

  // ram_rdata in the ack cycle belongs to the host's granted read.
  assign host_rdata = host_ack ? ram_rdata : '0;

endmodule

// File: rtl/function_generator_sequencer.sv
// rtl/function_generator_sequencer.sv - sample RAM playback sequencer driving the DAC bus
// Purpose: steps through the sample RAM at a programmable rate, updates the DAC with a
//          start strobe per sample, and shares the RAM port with the host.
// Ports:
//   clk, resetb                    clock, synchronous active-low reset
//   cfg_run, cfg_period            play enable; sample interval minus 1 (clamped to >= 2)
//   cfg_last_addr                  last sample address before wrap
//   host_req/we/addr/wdata         host RAM access, held until host_ack
//   host_rdata, host_ack           host completion
//   ram_en/we/addr/wdata, ram_rdata  sample RAM port
//   dac, dac_start                 current sample and update strobe
//   dbg_ram_addr_zero, dbg_state_run, dbg_active  debug strobes
`timescale 1ns/1ps
module function_generator_sequencer
  import function_generator_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                cfg_run,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [ADDR_W-1:0]   cfg_last_addr,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic [DATA_W-1:0]   host_rdata,
  output logic                host_ack,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [DATA_W-1:0]   dac,
  output logic                dac_start,
  output logic                dbg_ram_addr_zero,
  output logic                dbg_state_run,
  output logic                dbg_active
);

  fg_state_t           state;
  fg_state_t           next_state;
  logic [ADDR_W-1:0]   play_addr;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] period_eff;
  logic                cnt_zero;

  assign period_eff = (cfg_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : cfg_period;
  assign cnt_zero   = (cnt == '0);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cfg_run) next_state = FETCH;
      FETCH:   next_state = CAPTURE;
      CAPTURE: next_state = WAIT;
      WAIT:    if (cnt_zero) next_state = FETCH;
      default: next_state = IDLE;
    endcase
    if (!cfg_run) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state     <= IDLE;
      play_addr <= '0;
      cnt       <= '0;
      dac       <= '0;
      dac_start <= 1'b0;
    end else begin
      state     <= next_state;
      dac_start <= 1'b0;

      if (!cfg_run || state == IDLE) begin
        play_addr <= '0;
      end else if (state == WAIT && cnt_zero) begin
        play_addr <= (play_addr >= cfg_last_addr) ? '0 : play_addr + 1'b1;
      end

      // Loaded with period-1 at FETCH so FETCH-to-FETCH spans period+1 clocks.
      if (!cfg_run) begin
        cnt <= '0;
      end else if (state == FETCH) begin
        cnt <= period_eff - 1'b1;
      end else if (!cnt_zero) begin
        cnt <= cnt - 1'b1;
      end

      // A stop during CAPTURE discards the fetched sample.
      if (state == CAPTURE && cfg_run) begin
        dac       <= ram_rdata;
        dac_start <= 1'b1;
      end
    end
  end

  fg_ram_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_arb (
    .clk         (clk),
    .resetb      (resetb),
    .player_req  (state == FETCH),
    .player_addr (play_addr),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_ack    (host_ack),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  assign dbg_state_run     = (state != IDLE);
  assign dbg_ram_addr_zero = dbg_state_run & (play_addr == '0);
  assign dbg_active        = ram_en;

endmodule
